// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns CPU load/store requests into registered, word-aligned
// bus transactions and stalls the pipeline until they complete. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  DMType,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0]  state;
   logic [7:0]  wait_cnt;
   logic [2:0]  ld_type;
   logic [1:0]  ld_off;
   logic        req;
   logic        is_half;
   logic        is_byte;
   logic        legal;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ext_data;

   assign req     = mem_r | mem_w;
   assign is_half = (DMType == 3'b001) || (DMType == 3'b010);
   assign is_byte = (DMType == 3'b011) || (DMType == 3'b100);

`ifdef MISALIGN_TRAP_EN
   assign legal = !((is_half && addr[0]) || (!is_half && !is_byte && (addr[1:0] != 2'b00)));
`else
   assign legal = 1'b1;
`endif

   assign stall = ((state == S_IDLE) && req && legal) || (state == S_ACCESS);

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wdata;
      if (is_byte) begin
         be_nxt    = 4'b0001 << addr[1:0];
         wdata_nxt = {4{wdata[7:0]}};
      end else if (is_half) begin
         be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
         wdata_nxt = {2{wdata[15:0]}};
      end
   end

   // Load lane selection uses the offset latched at launch, not the live address.
   always_comb begin
      lane_h = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (ld_off)
         2'd0:    lane_b = bus_rdata[7:0];
         2'd1:    lane_b = bus_rdata[15:8];
         2'd2:    lane_b = bus_rdata[23:16];
         default: lane_b = bus_rdata[31:24];
      endcase
      case (ld_type)
         3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
         3'b010:  ext_data = {16'h0000, lane_h};
         3'b011:  ext_data = {{24{lane_b[7]}}, lane_b};
         3'b100:  ext_data = {24'h000000, lane_b};
         default: ext_data = bus_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so the bus request drops immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         wait_cnt  <= 8'd0;
         ld_type   <= 3'd0;
         ld_off    <= 2'd0;
         rdata     <= 32'd0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'd0;
         bus_wdata <= 32'd0;
      end else begin
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req && legal) begin
                  state     <= S_ACCESS;
                  wait_cnt  <= 8'd0;
                  ld_type   <= DMType;
                  ld_off    <= addr[1:0];
                  bus_req   <= 1'b1;
                  bus_we    <= mem_w;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= be_nxt;
                  bus_wdata <= wdata_nxt;
               end else if (req) begin
                  misalign <= 1'b1;
                  rdata    <= 32'd0;
               end
            end
            S_ACCESS: begin
               if (bus_ack) begin
                  rdata   <= ext_data;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  state   <= S_RESP;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  bus_err <= 1'b1;
                  rdata   <= 32'd0;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  state   <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT=4); follows MISALIGN_TRAP_EN like the DUT.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r, mem_w;
   logic [31:0] addr, wdata;
   logic [2:0]  DMType;
   logic [31:0] rdata;
   logic        stall, misalign, bus_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr), .wdata(wdata),
      .DMType(DMType), .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      string       name;
      logic [2:0]  dmt;
      logic [31:0] a;
      logic [31:0] rd;
      logic [3:0]  be;
      logic [31:0] exp;
   } load_vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; mem_r = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; DMType = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      #2;
      checks++; if ({bus_req, bus_we, bus_be, misalign, bus_err, stall} !== 9'd0) begin failures++; $display("FAIL reset_ctrl: got %b exp 0", {bus_req, bus_we, bus_be, misalign, bus_err, stall}); end
      checks++; if ({rdata, bus_addr, bus_wdata} !== 96'd0) begin failures++; $display("FAIL reset_data: got %h exp 0", {rdata, bus_addr, bus_wdata}); end
      tick; tick;
      rst = 1'b1;
   endtask

   task automatic test_loads;
      load_vec_t v [6];
      v[0] = '{"lb",   3'b011, 32'h13, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80};
      v[1] = '{"lhu",  3'b010, 32'h02, 32'h8001_0000, 4'b1100, 32'h0000_8001};
      v[2] = '{"lh",   3'b001, 32'h00, 32'h1234_8001, 4'b0011, 32'hFFFF_8001};
      v[3] = '{"lbu",  3'b100, 32'h11, 32'h0000_F700, 4'b0010, 32'h0000_00F7};
      v[4] = '{"lw",   3'b000, 32'h2C, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
      v[5] = '{"lw111", 3'b111, 32'h08, 32'h0102_0304, 4'b1111, 32'h0102_0304};
      for (int i = 0; i < 6; i++) begin
         tick;
         mem_r = 1'b1; addr = v[i].a; DMType = v[i].dmt;
         #2;
         checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL %s_idle: stall=%b req=%b exp stall=1 req=0", v[i].name, stall, bus_req); end
         tick;
         bus_ack = 1'b1; bus_rdata = v[i].rd;
         #2;
         checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL %s_access: req=%b we=%b stall=%b exp 1 0 1", v[i].name, bus_req, bus_we, stall); end
         checks++; if (bus_be !== v[i].be || bus_addr !== {v[i].a[31:2], 2'b00}) begin failures++; $display("FAIL %s_bus: be=%b addr=%h exp be=%b addr=%h", v[i].name, bus_be, bus_addr, v[i].be, {v[i].a[31:2], 2'b00}); end
         tick;
         bus_ack = 1'b0; bus_rdata = 32'hDEAD_0000;
         #2;
         checks++; if (rdata !== v[i].exp || stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL %s_resp: rdata=%h stall=%b req=%b exp %h 0 0", v[i].name, rdata, stall, bus_req, v[i].exp); end
         tick;
         #2;
         checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL %s_no_relaunch: req=%b exp 0", v[i].name, bus_req); end
         mem_r = 1'b0;
      end
   endtask

   task automatic test_store_half;
      tick;
      mem_w = 1'b1; addr = 32'h22; wdata = 32'h1234_ABCD; DMType = 3'b001;
      #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sh_idle_stall: got %b exp 1", stall); end
      for (int c = 0; c < 3; c++) begin
         tick;
         bus_ack = (c == 2);
         #2;
         checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL sh_access%0d: req=%b we=%b stall=%b exp 1 1 1", c, bus_req, bus_we, stall); end
         checks++; if (bus_addr !== 32'h20 || bus_be !== 4'b1100 || bus_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_bus%0d: addr=%h be=%b wdata=%h exp 20 1100 abcdabcd", c, bus_addr, bus_be, bus_wdata); end
      end
      tick;
      bus_ack = 1'b0;
      #2;
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0) begin failures++; $display("FAIL sh_resp: stall=%b req=%b we=%b exp 0 0 0", stall, bus_req, bus_we); end
      tick;
      mem_w = 1'b0;
   endtask

   task automatic test_timeout(input logic ack_last);
      tick;
      mem_r = 1'b1; addr = 32'h40; DMType = 3'b000;
      for (int c = 0; c < 5; c++) begin
         tick;
         if (c == 4 && ack_last) begin bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; end
         #2;
         checks++; if (stall !== 1'b1 || bus_req !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL to%0b_wait%0d: stall=%b req=%b err=%b exp 1 1 0", ack_last, c, stall, bus_req, bus_err); end
      end
      tick;
      bus_ack = 1'b0;
      #2;
      checks++; if (bus_err !== !ack_last || stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL to%0b_resp: err=%b stall=%b req=%b exp %b 0 0", ack_last, bus_err, stall, bus_req, !ack_last); end
      checks++; if (rdata !== (ack_last ? 32'h0BAD_F00D : 32'h0)) begin failures++; $display("FAIL to%0b_rdata: got %h", ack_last, rdata); end
      tick;
      mem_r = 1'b0;
      #2;
      checks++; if (bus_err !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL to%0b_idle: err=%b stall=%b exp 0 0", ack_last, bus_err, stall); end
   endtask

   task automatic test_misalign;
      tick;
      mem_r = 1'b1; addr = 32'h05; DMType = 3'b000;
      #2;
`ifdef MISALIGN_TRAP_EN
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall: got %b exp 0", stall); end
      tick;
      mem_r = 1'b0;
      #2;
      checks++; if (misalign !== 1'b1 || bus_req !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL mis_pulse: mis=%b req=%b rdata=%h exp 1 0 0", misalign, bus_req, rdata); end
      tick;
      #2;
      checks++; if (misalign !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL mis_end: mis=%b req=%b exp 0 0", misalign, bus_req); end
`else
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mis_stall: got %b exp 1", stall); end
      tick;
      bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      #2;
      checks++; if (bus_addr !== 32'h04 || bus_be !== 4'b1111 || misalign !== 1'b0) begin failures++; $display("FAIL mis_bus: addr=%h be=%b mis=%b exp 04 1111 0", bus_addr, bus_be, misalign); end
      tick;
      bus_ack = 1'b0; mem_r = 1'b0;
      #2;
      checks++; if (rdata !== 32'h5555_AAAA || misalign !== 1'b0) begin failures++; $display("FAIL mis_resp: rdata=%h mis=%b", rdata, misalign); end
`endif
   endtask

   task automatic test_back_to_back;
      tick;
      mem_w = 1'b1; addr = 32'h01; wdata = 32'h0000_005A; DMType = 3'b011;
      tick;
      bus_ack = 1'b1;
      #2;
      checks++; if (bus_be !== 4'b0010 || bus_wdata !== 32'h5A5A_5A5A || bus_we !== 1'b1) begin failures++; $display("FAIL sb_bus: be=%b wdata=%h we=%b exp 0010 5a5a5a5a 1", bus_be, bus_wdata, bus_we); end
      tick;
      bus_ack = 1'b0; addr = 32'h30; wdata = 32'h1122_3344; DMType = 3'b000;
      #2;
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL b2b_resp: stall=%b req=%b exp 0 0", stall, bus_req); end
      tick;
      #2;
      checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL b2b_idle: stall=%b req=%b exp 1 0", stall, bus_req); end
      tick;
      bus_ack = 1'b1;
      #2;
      checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h30 || bus_be !== 4'b1111 || bus_wdata !== 32'h1122_3344) begin failures++; $display("FAIL b2b_sw: req=%b addr=%h be=%b wdata=%h", bus_req, bus_addr, bus_be, bus_wdata); end
      tick;
      bus_ack = 1'b0; mem_w = 1'b0;
      #2;
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL b2b_done: stall=%b req=%b exp 0 0", stall, bus_req); end
   endtask

   task automatic test_reset_mid_access;
      tick;
      mem_w = 1'b1; addr = 32'h44; wdata = 32'h7777_7777; DMType = 3'b000;
      tick;
      #2;
      checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rst_pre: req=%b exp 1", bus_req); end
      rst = 1'b0; mem_w = 1'b0;
      #1;
      checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL rst_mid: req=%b we=%b addr=%h stall=%b exp all 0", bus_req, bus_we, bus_addr, stall); end
      tick; tick;
      rst = 1'b1;
      tick;
      mem_w = 1'b1; addr = 32'h30; wdata = 32'hDEAD_BEEF; DMType = 3'b000;
      #2;
      checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL rst_sw_idle: stall=%b req=%b exp 1 0", stall, bus_req); end
      tick;
      bus_ack = 1'b1;
      #2;
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_be !== 4'b1111) begin failures++; $display("FAIL rst_sw_bus: req=%b we=%b wdata=%h be=%b", bus_req, bus_we, bus_wdata, bus_be); end
      tick;
      bus_ack = 1'b0; mem_w = 1'b0;
      #2;
      checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL rst_sw_resp: stall=%b req=%b exp 0 0", stall, bus_req); end
   endtask

   initial begin
      test_reset;
      test_loads;
      test_store_half;
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_misalign;
      test_back_to_back;
      test_reset_mid_access;
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit between the pipelined CPU's EX/MEM outputs and a data memory with variable-latency request/acknowledge. Converts per-instruction store/load requests (address, store data, DMType) into word-aligned bus transactions with byte enables, sign/zero-extends load data, and stalls the pipeline until each access completes.

## Interface

Parameters:
- TIMEOUT, 255: ACCESS cycles without bus_ack before the access is aborted. Valid range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_r  in  1  load request in MEM stage
- mem_w  in  1  store request in MEM stage; wins if both mem_r and mem_w are high
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2 value)
- DMType  in  3  access type: 000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned; other codes act as word
- rdata  out  32  extended load data, valid in RESP cycle
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign  out  1  one-cycle misaligned-access pulse
- bus_err  out  1  one-cycle timeout pulse
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write, registered
- bus_addr  out  32  {addr[31:2], 2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  access complete; read data valid this cycle
- bus_rdata  in  32  read word

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE: if (mem_r|mem_w) and the access is legal, latch bus_* outputs, go ACCESS. Otherwise stay.
- ACCESS: bus_req=1 and all bus_* held stable. On bus_ack, capture extended rdata and go RESP. If the counter reaches TIMEOUT, pulse bus_err, set rdata=0, issue no write, and go RESP.
- RESP: one cycle with stall=0, go IDLE. The request still presented in this cycle is not relaunched.
- stall = (state==IDLE & (mem_r|mem_w) & legal) | (state==ACCESS).
- Byte enables:
  - word: 1111
  - halfword: 0011 if addr[1]=0, else 1100
  - byte: 0001<<addr[1:0]
- Store data lanes:
  - byte: wdata[7:0] replicated x4
  - halfword: wdata[15:0] replicated x2
  - word: wdata unchanged
- Load extension: select the lane by addr[1:0], then sign-extend (000/001/011) or zero-extend (010/100).
- Wait counter: 8 bits, cleared on ACCESS entry, increments each ACCESS cycle without ack. bus_ack on the same cycle the counter hits TIMEOUT counts as success.
- Reset (async, mid-access included):
  - state=IDLE
  - bus_req, bus_we, bus_addr, bus_be, bus_wdata = 0
  - rdata, misalign, bus_err, counter = 0
  - the bus slave must tolerate a dropped request.

## Timing

- Request in IDLE at cycle N. bus_req is high from N+1.
- Ack at cycle N+k: RESP at N+k+1, where rdata is valid and stall is low. The CPU advances at the end of N+k+1.
- Minimum access: 3 cycles (ack on first ACCESS cycle).
- stall is combinational from mem_r/mem_w/addr/DMType in IDLE; registered state elsewhere.
- misalign and bus_err are registered, one cycle wide.

## Configuration

- MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is illegal. No bus access, stall=0, misalign pulses high in cycle N+1, rdata=0.
- MISALIGN_TRAP_EN undefined: all accesses are legal and misalign is tied to 0.
  - halfword uses addr[1] and ignores addr[0]
  - word ignores addr[1:0]

## Test plan

- lb at addr 0x13, bus_rdata 0x80FF_0000, ack on first ACCESS cycle: bus_be=1000, rdata=0xFFFF_FF80, stall high 2 cycles.
- sh wdata 0x1234_ABCD at addr 0x22, ack after 3 cycles: bus_addr=0x20, bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1; stall high until RESP.
- lhu at addr 0x02, bus_rdata 0x8001_0000: rdata=0x0000_8001.
- lw with no ack, TIMEOUT=4: bus_err pulses once, rdata=0, FSM returns to IDLE, stall drops in RESP.
- lw at addr 0x05: with MISALIGN_TRAP_EN, misalign=1 for one cycle and bus_req stays 0; without it, bus_addr=0x04, bus_be=1111.
- rst low during ACCESS: bus_req=0 immediately. After release, the FSM is in IDLE and a new sw completes normally.
